// File: rtl/divider_if.sv
// divider_if: start/out_en handshake bundle for the sequential divider.
// The sticky signal exists only when DIV_STICKY_EN is defined.
interface divider_if #(
  parameter int WIDTH = 24
);
  logic                 start;
  logic [2*WIDTH-1:0]   p;
  logic [WIDTH-1:0]     d;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     r;
  logic                 ovf;
  logic                 busy;
  logic                 out_en;
`ifdef DIV_STICKY_EN
  logic                 sticky;
`endif

  modport master (
    output start, p, d,
    input  q, r, ovf, busy, out_en
`ifdef DIV_STICKY_EN
    , input sticky
`endif
  );

  modport slave (
    input  start, p, d,
    output q, r, ovf, busy, out_en
`ifdef DIV_STICKY_EN
    , output sticky
`endif
  );
endinterface

// File: rtl/divider.sv
// divider: sequential restoring divider, 2*WIDTH-bit dividend by WIDTH-bit
// divisor, one quotient bit per clock. Overflow (including d = 0) is detected
// at load and reported immediately with q = all ones, r = 0.
// Optional feature macro: DIV_STICKY_EN adds a registered sticky = (r != 0).
module divider #(
  parameter int WIDTH = 24
) (
  input  logic     clk,
  input  logic     reset,
  divider_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] div;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;
  logic             res_ovf;
  logic             busy_flag;
  logic             valid;
`ifdef DIV_STICKY_EN
  logic             res_sticky;
`endif

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             fits;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] dvd_step;
  logic             load_ovf;

  // One restoring step: W+1-bit trial so the bit shifted out of rem is kept.
  // When the trial fits, the true difference is below d, so W bits suffice.
  always_comb begin
    trial    = {rem, dvd[WIDTH-1]};
    fits     = (trial >= {1'b0, div});
    diff     = trial[WIDTH-1:0] - div;
    rem_step = fits ? diff : trial[WIDTH-1:0];
    dvd_step = {dvd[WIDTH-2:0], fits};
    load_ovf = (bus.p[2*WIDTH-1:WIDTH] >= bus.d);
  end

  // Control FSM and datapath; results only change on the DONE-entry edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      rem        <= '0;
      dvd        <= '0;
      div        <= '0;
      count      <= '0;
      res_q      <= '0;
      res_r      <= '0;
      res_ovf    <= 1'b0;
      busy_flag  <= 1'b0;
      valid      <= 1'b0;
`ifdef DIV_STICKY_EN
      res_sticky <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (bus.start) begin
            div       <= bus.d;
            rem       <= bus.p[2*WIDTH-1:WIDTH];
            dvd       <= bus.p[WIDTH-1:0];
            count     <= '0;
            busy_flag <= 1'b1;
            if (load_ovf) begin
              state      <= DONE;
              res_q      <= '1;
              res_r      <= '0;
              res_ovf    <= 1'b1;
              valid      <= 1'b1;
`ifdef DIV_STICKY_EN
              res_sticky <= 1'b0;
`endif
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem   <= rem_step;
          dvd   <= dvd_step;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state      <= DONE;
            res_q      <= dvd_step;
            res_r      <= rem_step;
            res_ovf    <= 1'b0;
            valid      <= 1'b1;
`ifdef DIV_STICKY_EN
            res_sticky <= |rem_step;
`endif
          end
        end
        DONE: begin
          valid     <= 1'b0;
          busy_flag <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.q      = res_q;
  assign bus.r      = res_r;
  assign bus.ovf    = res_ovf;
  assign bus.busy   = busy_flag;
  assign bus.out_en = valid;
`ifdef DIV_STICKY_EN
  assign bus.sticky = res_sticky;
`endif
endmodule

// File: tb/tb_divider.sv
// tb_divider: scoreboard bench for divider. The stimulus process pushes the
// arithmetically expected result (plain / and %) when a start is accepted; a
// monitor pops and compares on every out_en pulse.
module tb_divider;
  localparam int W = 24;

  logic clk = 1'b0;
  logic reset = 1'b0;
  longint cycle = 0;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         ovf;
    logic         sticky;
    longint       due;
  } exp_t;

  exp_t sb[$];

  divider_if #(.WIDTH(W)) bus ();

  divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: unsigned long division; overflow when the quotient needs > W bits.
  function automatic exp_t model(input logic [2*W-1:0] pv, input logic [W-1:0] dv, input longint k);
    exp_t e;
    longint unsigned pp = longint'(pv);
    longint unsigned dd = longint'(dv);
    if (dd == 0 || (pp / dd) > 64'(24'hFFFFFF)) begin
      e.q = '1; e.r = '0; e.ovf = 1'b1; e.sticky = 1'b0; e.due = k;
    end else begin
      e.q = W'(pp / dd); e.r = W'(pp % dd); e.ovf = 1'b0;
      e.sticky = ((pp % dd) != 0); e.due = k + W;
    end
    return e;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      compared++; mismatched++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", bus.busy, n);
    end
  endtask

  // Single-cycle start pulse with the expected result pushed at issue time.
  task automatic issue(input logic [2*W-1:0] pv, input logic [W-1:0] dv);
    wait_idle();
    bus.p = pv;
    bus.d = dv;
    bus.start = 1'b1;
    sb.push_back(model(pv, dv, cycle + 1));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  function automatic logic [2*W-1:0] rand_fit(input logic [W-1:0] dv);
    logic [W-1:0] hi = W'($urandom) % dv;
    logic [W-1:0] lo = W'($urandom);
    return {hi, lo};
  endfunction

  // Monitor: compare every out_en pulse against the head of the scoreboard.
  initial begin
    logic prev_en = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && bus.out_en === 1'b1) begin
        check("out_en_width", {63'd0, prev_en}, 64'd0);
        check("busy_with_out_en", {63'd0, bus.busy}, 64'd1);
        if (sb.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_out_en: got pulse at cycle %0d, required none", cycle);
        end else begin
          e = sb.pop_front();
          $display("txn cycle=%0d q=%06h r=%06h ovf=%0b (expect q=%06h r=%06h ovf=%0b)",
                   cycle, bus.q, bus.r, bus.ovf, e.q, e.r, e.ovf);
          check("q", 64'(bus.q), 64'(e.q));
          check("r", 64'(bus.r), 64'(e.r));
          check("ovf", 64'(bus.ovf), 64'(e.ovf));
          check("latency", 64'(cycle), 64'(e.due));
`ifdef DIV_STICKY_EN
          check("sticky", 64'(bus.sticky), 64'(e.sticky));
`endif
        end
      end
      prev_en = (reset === 1'b1) && (bus.out_en === 1'b1);
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached with %0d pending", sb.size());
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic [W-1:0] dv;
    logic [2*W-1:0] pv;
    longint k;
    bus.start = 1'b0;
    bus.p = '0;
    bus.d = '0;
    repeat (3) @(negedge clk);
    check("reset_q", 64'(bus.q), 64'd0);
    check("reset_r", 64'(bus.r), 64'd0);
    check("reset_ovf", 64'(bus.ovf), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_out_en", 64'(bus.out_en), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases
    issue(48'h7800_0000_0000, 24'hA00000);
    issue(48'd1000, 24'd7);
    issue(48'hFFFF_FE00_0001, 24'hFFFFFF);
    issue(48'd5, 24'd0);
    issue(48'h0000_0100_0000, 24'd1);

    // start pulsed during RUN is ignored
    issue(48'd123456789, 24'd1000);
    repeat (5) @(negedge clk);
    bus.p = 48'd99; bus.d = 24'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;

    // Reset in the middle of RUN aborts without out_en
    issue(48'h0000_1234_5678, 24'h00ABCD);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    void'(sb.pop_back());
    check("abort_q", 64'(bus.q), 64'd0);
    check("abort_r", 64'(bus.r), 64'd0);
    check("abort_ovf", 64'(bus.ovf), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_out_en", 64'(bus.out_en), 64'd0);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    issue(48'd1000, 24'd7);

    // Back-to-back with start held high
    wait_idle();
    dv = W'($urandom) | 24'h1;
    pv = rand_fit(dv);
    bus.p = pv; bus.d = dv; bus.start = 1'b1;
    k = cycle + 1;
    sb.push_back(model(pv, dv, k));
    for (int i = 1; i < 3; i++) begin
      while (cycle < k + 26 * (i - 1)) @(negedge clk);
      dv = W'($urandom) | 24'h1;
      pv = rand_fit(dv);
      bus.p = pv; bus.d = dv;
      sb.push_back(model(pv, dv, k + 26 * i));
    end
    while (cycle < k + 52) @(negedge clk);
    bus.start = 1'b0;

    // Randomized mix of overflow and fitting operands
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: begin dv = W'($urandom); pv = {W'($urandom), W'($urandom)}; end
        1: begin dv = W'($urandom_range(1, 255)); pv = rand_fit(dv); end
        2: begin dv = W'($urandom) | 24'h800000; pv = rand_fit(dv); end
        default: begin dv = W'($urandom) | 24'h1; pv = rand_fit(dv); end
      endcase
      issue(pv, dv);
    end

    begin
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (sb.size() != 0) begin
        compared++; mismatched++;
        $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      end
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
